// File: rtl/ram_bist_pkg.sv
// Shared encodings for the RAM march-test controller: FSM states, march phases,
// cs/rw strobe levels and small phase helpers.
package ram_bist_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_e;

  typedef enum logic [PHASE_W-1:0] {
    PH_W0,
    PH_R0,
    PH_W1,
    PH_R1
  } phase_e;

  localparam logic CS_SEL   = 1'b0;
  localparam logic CS_DESEL = 1'b1;
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  function automatic logic phase_is_read(input phase_e p);
    logic r;
    r = (p == PH_R0) || (p == PH_R1);
    return r;
  endfunction

  // W1/R1 use the bitwise inverse of the base pattern
  function automatic logic phase_is_inv(input phase_e p);
    logic r;
    r = (p == PH_W1) || (p == PH_R1);
    return r;
  endfunction

  function automatic phase_e phase_next(input phase_e p);
    phase_e n;
    case (p)
      PH_W0:   n = PH_R0;
      PH_R0:   n = PH_W1;
      PH_W1:   n = PH_R1;
      default: n = PH_W0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ram_bist_pattern.sv
// Combinational march data generator: (addr resized to DATA_W) ^ SEED,
// inverted in the W1/R1 phases.
module ram_bist_pattern
  import ram_bist_pkg::*;
#(
  parameter int unsigned         ADDR_W = 4,
  parameter int unsigned         DATA_W = 4,
  parameter logic [DATA_W-1:0]   SEED   = '0
) (
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic [DATA_W-1:0]  pattern_c_o
);

  logic [DATA_W-1:0] base_c;

  always_comb begin
    base_c      = DATA_W'(addr_i) ^ SEED;
    pattern_c_o = phase_is_inv(phase_e'(phase_i)) ? ~base_c : base_c;
  end

endmodule

// File: rtl/ram_bist_ctrl.sv
// Four-pass march BIST initiator for an asynchronous cs/rw RAM.
// Build option RAM_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W = 4,
  parameter int unsigned       DATA_W = 4,
  parameter logic [DATA_W-1:0] SEED   = '0,
  parameter int unsigned       ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_adrs,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              ram_cs,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_adrs,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  state_e            state_q;
  phase_e            phase_q;
  logic [ADDR_W-1:0] addr_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_adrs_q;
  logic [ERR_W-1:0]  err_cnt_q;
  logic              ram_cs_q;
  logic              ram_rw_q;
  logic [ADDR_W-1:0] ram_adrs_q;
  logic [DATA_W-1:0] ram_data_in_q;

  logic [ERR_W-1:0]  err_cnt_d;
  logic [ADDR_W-1:0] fail_adrs_d;
  logic [DATA_W-1:0] expect_c;
  logic [DATA_W-1:0] wdata_c;
  logic [ADDR_W-1:0] nxt_addr_c;
  phase_e            nxt_phase_c;
  logic              last_addr_c;
  logic              run_end_c;
  logic              mismatch_c;
  logic              stop_c;

  // Reference data for the access in flight (compare value in R phases)
  ram_bist_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_expect (
    .addr_i      (addr_q),
    .phase_i     (phase_q),
    .pattern_c_o (expect_c)
  );

  // Write data for the access about to be set up
  ram_bist_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SEED   (SEED)
  ) u_wdata (
    .addr_i      (nxt_addr_c),
    .phase_i     (nxt_phase_c),
    .pattern_c_o (wdata_c)
  );

  // Next access address/phase and mismatch bookkeeping
  always_comb begin
    last_addr_c = (addr_q == ADDR_LAST);
    run_end_c   = last_addr_c && (phase_q == PH_R1);
    nxt_addr_c  = '0;
    nxt_phase_c = PH_W0;
    if (state_q == S_ACCESS) begin
      nxt_addr_c  = last_addr_c ? '0 : addr_q + ADDR_W'(1);
      nxt_phase_c = last_addr_c ? phase_next(phase_q) : phase_q;
    end

    mismatch_c  = (state_q == S_ACCESS) && phase_is_read(phase_q) &&
                  (ram_data_out != expect_c);
    err_cnt_d   = err_cnt_q;
    fail_adrs_d = fail_adrs_q;
    if (mismatch_c) begin
      if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + ERR_W'(1);
      if (err_cnt_q == '0)      fail_adrs_d = addr_q;
    end

`ifdef RAM_BIST_STOP_ON_FAIL_EN
    stop_c = mismatch_c;
`else
    stop_c = 1'b0;
`endif
  end

  // Control FSM; async reset deselects the RAM without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      phase_q       <= PH_W0;
      addr_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_adrs_q   <= '0;
      err_cnt_q     <= '0;
      ram_cs_q      <= CS_DESEL;
      ram_rw_q      <= RW_READ;
      ram_adrs_q    <= '0;
      ram_data_in_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q       <= S_SETUP;
            phase_q       <= nxt_phase_c;
            addr_q        <= nxt_addr_c;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_adrs_q   <= '0;
            err_cnt_q     <= '0;
            ram_cs_q      <= CS_DESEL;
            ram_rw_q      <= RW_WRITE;
            ram_adrs_q    <= nxt_addr_c;
            ram_data_in_q <= wdata_c;
          end
        end
        S_SETUP: begin
          state_q  <= S_ACCESS;
          ram_cs_q <= CS_SEL;
        end
        S_ACCESS: begin
          ram_cs_q    <= CS_DESEL;
          err_cnt_q   <= err_cnt_d;
          fail_adrs_q <= fail_adrs_d;
          if (run_end_c || stop_c) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
          end else begin
            state_q    <= S_SETUP;
            addr_q     <= nxt_addr_c;
            phase_q    <= nxt_phase_c;
            ram_adrs_q <= nxt_addr_c;
            if (phase_is_read(nxt_phase_c)) begin
              ram_rw_q <= RW_READ;
            end else begin
              ram_rw_q      <= RW_WRITE;
              ram_data_in_q <= wdata_c;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_adrs   = fail_adrs_q;
  assign err_cnt     = err_cnt_q;
  assign ram_cs      = ram_cs_q;
  assign ram_rw      = ram_rw_q;
  assign ram_adrs    = ram_adrs_q;
  assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: faulty 16x4 RAM device model, fixed fault table,
// corner sequences and random faults scored against a march-test reference.
module tb_ram_bist_ctrl;

  localparam logic [3:0] SEED = 4'h0;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, done, pass;
  logic [3:0] fail_adrs;
  logic [7:0] err_cnt;
  logic       ram_cs, ram_rw;
  logic [3:0] ram_adrs, ram_data_in, ram_data_out;

  ram_bist_ctrl #(
    .ADDR_W (4),
    .DATA_W (4),
    .SEED   (SEED),
    .ERR_W  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_adrs    (fail_adrs),
    .err_cnt      (err_cnt),
    .ram_cs       (ram_cs),
    .ram_rw       (ram_rw),
    .ram_adrs     (ram_adrs),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fault configuration shared by the device model and the reference
  logic       stuck_en, stuck_val, alias_en;
  logic [3:0] stuck_addr, alias_src, alias_dst;
  logic [1:0] stuck_bit;

  // RAM device: one optional remapped address, one optional stuck bit
  logic [3:0] mem_dev [16];
  logic [3:0] dev_phys, dev_rd;

  always_comb begin
    dev_phys = (alias_en && ram_adrs == alias_src) ? alias_dst : ram_adrs;
    dev_rd   = mem_dev[dev_phys];
    if (stuck_en && dev_phys == stuck_addr) dev_rd[stuck_bit] = stuck_val;
    ram_data_out = dev_rd;
  end

  always @(posedge clk) begin
    if (ram_cs == 1'b0 && ram_rw == 1'b1) mem_dev[dev_phys] <= ram_data_in;
  end

  // Protocol monitor sampled mid-cycle
  int         mon_wr = 0, mon_rd = 0, mon_viol = 0;
  logic       prev_cs = 1'b1, prev_rw = 1'b0;
  logic [3:0] prev_adrs = 4'h0, prev_data = 4'h0;

  always @(negedge clk) begin
    if (ram_cs == 1'b0) begin
      if (prev_cs == 1'b0) mon_viol++;
      if (ram_adrs !== prev_adrs || ram_rw !== prev_rw || ram_data_in !== prev_data) mon_viol++;
      if (ram_rw) mon_wr++;
      else        mon_rd++;
    end
    prev_cs   = ram_cs;
    prev_rw   = ram_rw;
    prev_adrs = ram_adrs;
    prev_data = ram_data_in;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // March-test reference: walk the four passes over an array image of the RAM
  task automatic ref_run(output int err, output int fadr, output int lat);
    logic [3:0] m [16];
    logic [3:0] pat, rd;
    int acc, pa;
    bit stop;
    err = 0; fadr = 0; acc = 0; stop = 0;
    for (int ph = 0; ph < 4; ph++) begin
      for (int a = 0; a < 16; a++) begin
        if (!stop) begin
          pat = 4'(a) ^ SEED;
          if (ph >= 2) pat = ~pat;
          pa = (alias_en && a == int'(alias_src)) ? int'(alias_dst) : a;
          acc++;
          if (ph % 2 == 0) begin
            m[pa] = pat;
          end else begin
            rd = m[pa];
            if (stuck_en && pa == int'(stuck_addr)) rd[stuck_bit] = stuck_val;
            if (rd != pat) begin
              if (err == 0) fadr = a;
              if (err < 255) err++;
`ifdef RAM_BIST_STOP_ON_FAIL_EN
              stop = 1;
`endif
            end
          end
        end
      end
    end
    lat = 2 * acc;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges until done; optionally pulse start while busy at edge k
  task automatic wait_done(input int k, output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1 start = 1'b0;
      n++;
      if (done) break;
      if (n >= 300) begin
        n = -1;
        break;
      end
      if (k != 0 && n == k && busy) start = 1'b1;
    end
  endtask

  typedef struct {
    logic       s_en;
    logic [3:0] s_addr;
    logic [1:0] s_bit;
    logic       s_val;
    logic       a_en;
    logic [3:0] a_src;
    logic [3:0] a_dst;
    int         exp_err;
    int         exp_fail;
    int         exp_lat;
    logic       exp_pass;
  } vec_t;

  vec_t vecs [5];

  task automatic set_fault(input vec_t v);
    stuck_en = v.s_en;  stuck_addr = v.s_addr; stuck_bit = v.s_bit; stuck_val = v.s_val;
    alias_en = v.a_en;  alias_src  = v.a_src;  alias_dst = v.a_dst;
  endtask

  initial begin
    int n, e_err, e_fadr, e_lat, wr0, rd0;
    vec_t none_v;

    vecs[0] = '{1'b0, 4'd0,  2'd0, 1'b0, 1'b0, 4'd0, 4'd0,  0, 0,  128, 1'b1};
`ifdef RAM_BIST_STOP_ON_FAIL_EN
    vecs[1] = '{1'b1, 4'd5,  2'd2, 1'b0, 1'b0, 4'd0, 4'd0,  1, 5,  44,  1'b0};
    vecs[2] = '{1'b0, 4'd0,  2'd0, 1'b0, 1'b1, 4'd3, 4'd11, 1, 3,  40,  1'b0};
    vecs[3] = '{1'b1, 4'd0,  2'd0, 1'b1, 1'b0, 4'd0, 4'd0,  1, 0,  34,  1'b0};
    vecs[4] = '{1'b1, 4'd15, 2'd3, 1'b1, 1'b0, 4'd0, 4'd0,  1, 15, 128, 1'b0};
`else
    vecs[1] = '{1'b1, 4'd5,  2'd2, 1'b0, 1'b0, 4'd0, 4'd0,  1, 5,  128, 1'b0};
    vecs[2] = '{1'b0, 4'd0,  2'd0, 1'b0, 1'b1, 4'd3, 4'd11, 2, 3,  128, 1'b0};
    vecs[3] = '{1'b1, 4'd0,  2'd0, 1'b1, 1'b0, 4'd0, 4'd0,  1, 0,  128, 1'b0};
    vecs[4] = '{1'b1, 4'd15, 2'd3, 1'b1, 1'b0, 4'd0, 4'd0,  1, 15, 128, 1'b0};
`endif
    none_v = vecs[0];

    rst = 1'b1;
    start = 1'b0;
    set_fault(none_v);
    for (int i = 0; i < 16; i++) mem_dev[i] = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({busy, done, pass, fail_adrs, err_cnt, ram_cs, ram_rw, ram_adrs, ram_data_in}),
          32'({1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0}));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fixed fault table
    for (int i = 0; i < 5; i++) begin
      set_fault(vecs[i]);
      wr0 = mon_wr;
      rd0 = mon_rd;
      pulse_start();
      wait_done(0, n);
      check($sformatf("vec%0d_latency", i),   32'(n),         32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_err_cnt", i),   32'(err_cnt),   32'(vecs[i].exp_err));
      check($sformatf("vec%0d_fail_adrs", i), 32'(fail_adrs), 32'(vecs[i].exp_fail));
      check($sformatf("vec%0d_pass", i),      32'(pass),      32'(vecs[i].exp_pass));
      check($sformatf("vec%0d_busy", i),      32'(busy),      32'(0));
      if (i == 0) begin
        check("ideal_write_strobes", 32'(mon_wr - wr0), 32'(32));
        check("ideal_read_strobes",  32'(mon_rd - rd0), 32'(32));
      end
    end

    // Restart from DONE clears results; a start pulse while busy is ignored
    set_fault(vecs[1]);
    pulse_start();
    check("restart_cleared",
          32'({busy, done, pass, fail_adrs, err_cnt}),
          32'({1'b1, 1'b0, 1'b0, 4'h0, 8'h00}));
    wait_done(20, n);
    check("busy_start_latency",   32'(n),         32'(vecs[1].exp_lat));
    check("busy_start_err_cnt",   32'(err_cnt),   32'(vecs[1].exp_err));
    check("busy_start_fail_adrs", 32'(fail_adrs), 32'(vecs[1].exp_fail));
    check("busy_start_done",      32'(done),      32'(1));

    // Asynchronous reset during an ACCESS cycle
    set_fault(none_v);
    pulse_start();
    repeat (41) @(posedge clk);
    #1;
    check("midrun_cs_selected", 32'(ram_cs), 32'(0));
    #2 rst = 1'b1;
    #1;
    check("midrun_async_reset",
          32'({busy, done, pass, fail_adrs, err_cnt, ram_cs, ram_rw, ram_adrs, ram_data_in}),
          32'({1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 4'h0}));
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset_idle", 32'({busy, done}), 32'(0));
    pulse_start();
    wait_done(0, n);
    check("after_reset_latency", 32'(n),    32'(128));
    check("after_reset_pass",    32'(pass), 32'(1));

    // Random faults against the reference model
    for (int r = 0; r < 24; r++) begin
      stuck_en   = 1'($urandom_range(0, 1));
      stuck_addr = 4'($urandom_range(0, 15));
      stuck_bit  = 2'($urandom_range(0, 3));
      stuck_val  = 1'($urandom_range(0, 1));
      alias_en   = 1'($urandom_range(0, 1));
      alias_src  = 4'($urandom_range(0, 15));
      alias_dst  = alias_src ^ 4'($urandom_range(1, 15));
      ref_run(e_err, e_fadr, e_lat);
      pulse_start();
      wait_done(int'($urandom_range(1, 150)), n);
      check($sformatf("rnd%0d_latency", r),   32'(n),         32'(e_lat));
      check($sformatf("rnd%0d_err_cnt", r),   32'(err_cnt),   32'(e_err));
      check($sformatf("rnd%0d_fail_adrs", r), 32'(fail_adrs), 32'(e_fadr));
      check($sformatf("rnd%0d_pass", r),      32'(pass),      32'(e_err == 0));
    end

    check("protocol_violations", 32'(mon_viol), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
Initiator-side controller for the asynchronous cs/rw RAM interface used by ram16x4 and the tiled 256x32 array. It drives chip select, read/write, address and write data. Each run performs a four-pass march test (write pattern, read/compare, write inverse, read/compare) and reports pass/fail, the first failing address and an error count. It sits between system start logic and one RAM instance.

Parameters:
ADDR_W, 4, RAM address width; depth is 2**ADDR_W.
DATA_W, 4, RAM data width.
SEED, 0 (DATA_W bits), XOR mask applied to the base pattern.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a run
busy  out  1  high while a run is in progress
done  out  1  high in DONE state, held until the next start
pass  out  1  valid while done=1; 1 if err_cnt==0
fail_adrs  out  ADDR_W  address of the first mismatch
err_cnt  out  ERR_W  mismatch count, saturating
ram_cs  out  1  chip select, active-low (0 = selected)
ram_rw  out  1  1 = write, 0 = read
ram_adrs  out  ADDR_W  RAM address
ram_data_in  out  DATA_W  write data to RAM
ram_data_out  in  DATA_W  read data from RAM (combinational)

Behaviour:
- All outputs are registered. Reset values: ram_cs=1, ram_rw=0, ram_adrs=0, ram_data_in=0, busy=0, done=0, pass=0, fail_adrs=0, err_cnt=0, state=IDLE, phase=W0.
- Reset is asynchronous. Mid-run it forces ram_cs=1 immediately, with no clock edge, so a write is never left enabled.
- States: IDLE, SETUP, ACCESS, DONE. Phases: W0, R0, W1, R1.
- IDLE or DONE with start=1: clear err_cnt, fail_adrs and pass; set addr=0, phase=W0; go to SETUP; busy=1, done=0.
- start is ignored in SETUP and ACCESS.
- SETUP: ram_cs=1. Drive ram_adrs=addr and ram_rw=1 for W phases, 0 for R phases. Drive ram_data_in = pattern (W0) or ~pattern (W1); hold its previous value in R phases. Then go to ACCESS.
- ACCESS: ram_cs=0. adrs, rw and data are held unchanged from SETUP.
- Every access is exactly 2 cycles. cs is never low on two consecutive cycles, and adrs/rw/data never change while cs=0.
- pattern = (addr zero-extended or truncated to DATA_W) XOR SEED.
- R-phase compare: at the edge ending ACCESS, sample ram_data_out and compare it with pattern (R0) or ~pattern (R1).
- On mismatch: err_cnt increments, saturating at 2**ERR_W-1. If this is the first mismatch, fail_adrs=addr.
- After ACCESS: if addr is the last address, wrap addr to 0 and advance the phase. After R1, go to DONE. Otherwise increment addr and return to SETUP.
- DONE: busy=0, done=1, pass=(err_cnt==0); ram_cs=1.
- Latency: done rises on the 2*4*2**ADDR_W-th edge after the edge that samples start. This is 128 edges for ADDR_W=4.

Optional Feature:
Macro: RAM_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch goes directly from ACCESS to DONE. fail_adrs is latched and err_cnt=1.
- Undefined: all four phases always run to completion.

Decomposition:
- Package ram_bist_pkg holds:
  - state encoding and phase encoding;
  - CS_SEL=0 and CS_DESEL=1;
  - RW_READ=0 and RW_WRITE=1.
- Sub-module ram_bist_pattern: combinational expected/write-data generator with inputs addr and phase, parameterized by ADDR_W, DATA_W and SEED.

Test Plan:
- Ideal 16x4 model, SEED=0; pulse start -> done high exactly 128 edges later, pass=1, err_cnt=0, fail_adrs=0.
- Bit 2 at address 5 stuck at 0 -> R0 reads 4'b0001 against expected 4'b0101; R1 matches. Result: err_cnt=1, fail_adrs=5, pass=0.
- RAM ignores address bit 3 (address 3 aliases 11) -> mismatches at address 3 in both R0 and R1. Result: err_cnt=2, fail_adrs=3.
- Protocol monitor over a full run -> no consecutive cs=0 cycles; adrs/rw/data stable whenever cs=0; exactly 32 write strobes and 32 read strobes.
- Assert rst during cycle 40 -> ram_cs=1 and all outputs at reset values before the next edge. A new start then completes in 128 edges.
- With RAM_BIST_STOP_ON_FAIL_EN and the stuck-at fault at address 5 -> done on edge 44, err_cnt=1, fail_adrs=5. A start pulse during busy has no effect; a start pulse in DONE restarts the run and clears results.
